// File: rtl/vid_capture_pkg.sv
// vid_capture_pkg
// Shared types and constants for the vid_capture slice.
//   cap_state_t : capture FSM states (WAIT_FRAME, BLANK, ACTIVE)
//   DM_*        : dither_mode encodings (any value above DM_TEMPORAL behaves as DM_TEMPORAL)
//   ppw_log2    : ceil(log2) helper used to size the pixels-per-word index
package vid_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    BLANK,
    ACTIVE
  } cap_state_t;

  localparam logic [1:0] DM_NONE     = 2'd0;
  localparam logic [1:0] DM_ORDERED  = 2'd1;
  localparam logic [1:0] DM_TEMPORAL = 2'd2;

  // Smallest r with 2**r >= ppw; PPW is expected to be a power of two.
  function automatic int ppw_log2(input int ppw);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < ppw) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vid_quant.sv
// vid_quant
// Combinational dither and quantise of one pixel from IN_W to OUT_W bits.
// Ports:
//   pixel [IN_W-1:0] : raw pixel value
//   x, y, frame [1:0]: low bits of pixel x, line y and frame number
//   mode [1:0]       : dither mode (DM_NONE / DM_ORDERED / DM_TEMPORAL, 3 = 2)
//   q [OUT_W-1:0]    : quantised pixel
module vid_quant
  import vid_capture_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2
) (
  input  logic [IN_W-1:0]  pixel,
  input  logic [1:0]       x,
  input  logic [1:0]       y,
  input  logic [1:0]       frame,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] q
);

  localparam int SH = IN_W - OUT_W;
  localparam logic [3:0]    D_MASK = 4'((1 << SH) - 1);
  localparam logic [IN_W:0] Q_MAX  = (IN_W + 1)'((1 << OUT_W) - 1);

  logic [3:0]    sum_xy;
  logic [3:0]    d;
  logic [IN_W:0] ext;
  logic [IN_W:0] shifted;

  // The dither offset is added at IN_W+1 bits so a bright pixel plus offset
  // cannot wrap; the result is then clamped to the largest output code.
  always_comb begin
    sum_xy = {2'b00, x} + {2'b00, y};
    case (mode)
      DM_NONE:    d = 4'd0;
      DM_ORDERED: d = sum_xy & D_MASK;
      default:    d = (sum_xy + {2'b00, frame}) & D_MASK;
    endcase
    ext     = {1'b0, pixel} + (IN_W + 1)'(d);
    shifted = ext >> SH;
    q       = (shifted > Q_MAX) ? OUT_W'(Q_MAX) : OUT_W'(shifted);
  end

endmodule

// File: rtl/vid_capture.sv
// vid_capture
// Samples a DE/VSYNC pixel stream, quantises each pixel and packs PPW pixels
// per VRAM word, issuing one registered write per word (plus a partial-word
// flush at line end).
// Ports:
//   rgb_clk, rst_n      : pixel clock, asynchronous active-low reset
//   rgb_de, rgb_vsync   : data enable, vertical sync (active high)
//   rgb_data [IN_W-1:0] : pixel value
//   dither_mode [1:0]   : 0 none, 1 ordered, 2/3 ordered + temporal
//   vram_addr           : {y, x >> log2(PPW)} of the written word
//   vram_data           : packed pixels, pixel 0 in the LSBs
//   vram_we             : one-cycle write strobe
//   frame_no            : frames started since reset (wraps)
//   line_overflow       : sticky, a line was too long or y saturated
module vid_capture
  import vid_capture_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 2,
  parameter int WORD_W  = 8,
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int FRAME_W = 8,
  localparam int PPW     = WORD_W / OUT_W,
  localparam int PPW_LOG = ppw_log2(PPW),
  localparam int A_W     = Y_W + X_W - PPW_LOG
) (
  input  logic               rgb_clk,
  input  logic               rst_n,
  input  logic               rgb_de,
  input  logic               rgb_vsync,
  input  logic [IN_W-1:0]    rgb_data,
  input  logic [1:0]         dither_mode,
  output logic [A_W-1:0]     vram_addr,
  output logic [WORD_W-1:0]  vram_data,
  output logic               vram_we,
  output logic [FRAME_W-1:0] frame_no,
  output logic               line_overflow
);

  localparam logic [X_W-1:0] X_MAX     = '1;
  localparam logic [Y_W-1:0] Y_MAX     = '1;
  localparam logic [X_W-1:0] SLOT_LAST = X_W'(PPW - 1);

  cap_state_t          state;
  logic                vsync_q;
  logic                de_block;
  logic                x_full;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [WORD_W-1:0]   pack;
  logic                pack_busy;

  logic                vsync_rise;
  logic                take_pixel;
  logic                line_end;
  logic [X_W-1:0]      slot;
  logic                slot_last;
  logic [X_W-PPW_LOG-1:0] x_word;
  logic [OUT_W-1:0]    quant_px;
  logic [WORD_W-1:0]   pack_ins;

  vid_quant #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_quant (
    .pixel (rgb_data),
    .x     (x[1:0]),
    .y     (y[1:0]),
    .frame (frame_no[1:0]),
    .mode  (dither_mode),
    .q     (quant_px)
  );

  // de_block keeps a line that was already running when VSYNC rose from
  // being captured; it only clears once DE has been seen low.
  always_comb begin
    vsync_rise = rgb_vsync & ~vsync_q;
    take_pixel = ((state == BLANK) && rgb_de && !de_block) ||
                 ((state == ACTIVE) && rgb_de);
    line_end   = (state == ACTIVE) && !rgb_de;
    slot       = x & SLOT_LAST;
    slot_last  = (slot == SLOT_LAST);
    x_word     = x[X_W-1:PPW_LOG];
    pack_ins   = pack | (WORD_W'(quant_px) << (int'(slot) * OUT_W));
  end

  // Capture FSM, counters, pack buffer and registered VRAM write port.
  // A VSYNC rise overrides everything else in the same cycle.
  always_ff @(posedge rgb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_FRAME;
      vsync_q       <= 1'b0;
      de_block      <= 1'b0;
      x_full        <= 1'b0;
      x             <= '0;
      y             <= '0;
      pack          <= '0;
      pack_busy     <= 1'b0;
      vram_addr     <= '0;
      vram_data     <= '0;
      vram_we       <= 1'b0;
      frame_no      <= '0;
      line_overflow <= 1'b0;
    end else begin
      vsync_q <= rgb_vsync;
      vram_we <= 1'b0;
      if (!rgb_de) de_block <= 1'b0;

      if (vsync_rise) begin
        state     <= BLANK;
        x         <= '0;
        y         <= '0;
        x_full    <= 1'b0;
        pack      <= '0;
        pack_busy <= 1'b0;
        frame_no  <= frame_no + FRAME_W'(1);
        de_block  <= rgb_de;
      end else if (take_pixel) begin
        state <= ACTIVE;
        // Once x has saturated the rest of the line is dropped.
        if (!x_full) begin
          if (slot_last) begin
            vram_we   <= 1'b1;
            vram_addr <= {y, x_word};
            vram_data <= pack_ins;
            pack      <= '0;
            pack_busy <= 1'b0;
          end else begin
            pack      <= pack_ins;
            pack_busy <= 1'b1;
          end
          if (x == X_MAX) begin
            x_full        <= 1'b1;
            line_overflow <= 1'b1;
          end else begin
            x <= x + X_W'(1);
          end
        end
      end else if (line_end) begin
        state <= BLANK;
        // x already points past the last stored pixel, so x_word still
        // addresses the partial word being flushed.
        if (pack_busy) begin
          vram_we   <= 1'b1;
          vram_addr <= {y, x_word};
          vram_data <= pack;
        end
        pack      <= '0;
        pack_busy <= 1'b0;
        x         <= '0;
        x_full    <= 1'b0;
        if (y == Y_MAX) line_overflow <= 1'b1;
        else            y <= y + Y_W'(1);
      end
    end
  end

endmodule
